// File: rtl/serial_bit_tx_pkg.sv
// ============================================================================
// Module : serial_tx_pkg
// Brief  : Shared types, widths and parity helper for the serial bit transmitter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    localparam int GAP_CNT_W = 8;

    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_bit_tx_if.sv
// ============================================================================
// Module : serial_bit_tx_if
// Brief  : Word handshake and serial stream signals of the serial bit transmitter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_bit_tx_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             last;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  bit_out,
        input  bit_valid,
        input  last,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output bit_out,
        output bit_valid,
        output last,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/serial_shift_reg.sv
// ============================================================================
// Module : serial_shift_reg
// Brief  : Loadable WIDTH-bit shift register with a look-ahead serial output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             load_i,
    input  wire logic             shift_i,
    input  wire logic [WIDTH-1:0] data_i,
    output logic                  serial_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] shifted;
    logic             first_bit;
    logic             next_bit;

    // serial_o is the bit that becomes current after the coming edge:
    // the head of a word being loaded, or the successor of the current head.
    generate
        if (MSB_FIRST) begin : g_msb
            assign first_bit = data_i[WIDTH-1];
            assign next_bit  = data_q[WIDTH-2];
            assign shifted   = data_q << 1;
        end else begin : g_lsb
            assign first_bit = data_i[0];
            assign next_bit  = data_q[1];
            assign shifted   = data_q >> 1;
        end
    endgenerate

    assign serial_o = load_i ? first_bit : next_bit;

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end else if (shift_i) begin
            data_q <= shifted;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_bit_tx.sv
// ============================================================================
// Module : serial_bit_tx
// Brief  : Serializes handshaked parallel words onto a single-bit stream.
//          Optional even-parity bit per word: define SERIAL_TX_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_bit_tx
    import serial_tx_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_BIT   = 1'b0,
    parameter bit   MSB_FIRST  = 1'b1
) (
    input  wire logic      clock,
    input  wire logic      reset,
    serial_bit_tx_if.slave bus
);

    localparam int CNT_W   = $clog2(WIDTH + 1);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
`ifdef SERIAL_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GAP_CNT_W-1:0]   gap_q, gap_d;
    logic                   parity_q, parity_d;
    logic                   bit_out_q, bit_out_d;
    logic                   bit_valid_q, bit_valid_d;
    logic                   last_q, last_d;

    logic                   last_shift;
    logic                   ready;
    logic                   accept;
    logic                   sr_shift;
    logic                   sr_serial;

    assign last_shift = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
    assign accept     = bus.in_valid && ready;
    assign sr_shift   = (state_q == ST_SHIFT) && !last_shift;

    // A new word may be taken on the closing cycle of the current word only
    // when nothing (parity or gap) follows it, giving bubble-free streaming.
    always_comb begin
        ready = 1'b0;
        case (state_q)
            ST_IDLE:   ready = 1'b1;
            ST_SHIFT:  ready = last_shift && !PARITY_EN && !HAS_GAP;
            ST_PARITY: ready = !HAS_GAP;
            default:   ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        gap_d    = '0;
        parity_d = parity_q;
        if (accept) begin
            parity_d = even_parity(32'(bus.in_data));
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!last_shift) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (PARITY_EN) begin
                    state_d = ST_PARITY;
                end else if (HAS_GAP) begin
                    state_d = ST_GAP;
                end else if (accept) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PARITY: begin
                if (HAS_GAP) begin
                    state_d = ST_GAP;
                end else if (accept) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stream outputs are registered, so they follow the next state.
        bit_valid_d = (state_d == ST_SHIFT) || (state_d == ST_PARITY);
        bit_out_d   = IDLE_BIT;
        if (state_d == ST_SHIFT) begin
            bit_out_d = sr_serial;
        end else if (state_d == ST_PARITY) begin
            bit_out_d = parity_q;
        end
        if (PARITY_EN) begin
            last_d = (state_d == ST_PARITY);
        end else begin
            last_d = (state_d == ST_SHIFT) && (cnt_d == CNT_W'(WIDTH - 1));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            parity_q    <= 1'b0;
            bit_out_q   <= IDLE_BIT;
            bit_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            parity_q    <= parity_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            last_q      <= last_d;
        end
    end

    serial_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clock    (clock),
        .reset    (reset),
        .load_i   (accept),
        .shift_i  (sr_shift),
        .data_i   (bus.in_data),
        .serial_o (sr_serial)
    );

    assign bus.in_ready  = ready;
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.last      = last_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_bit_tx.sv
// ============================================================================
// Module : tb_serial_bit_tx
// Brief  : Directed self-checking bench for serial_bit_tx with a bit scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_bit_tx;

    localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int WL = W + PAR;

    logic clock = 1'b0;
    logic rst0;
    logic rst1;
    always #5 clock = ~clock;

    serial_bit_tx_if #(.WIDTH(W)) if0 ();
    serial_bit_tx_if #(.WIDTH(W)) if1 ();

    serial_bit_tx #(.WIDTH(W), .GAP_CYCLES(0), .IDLE_BIT(1'b0), .MSB_FIRST(1'b1)) dut0 (
        .clock (clock),
        .reset (rst0),
        .bus   (if0)
    );

    serial_bit_tx #(.WIDTH(W), .GAP_CYCLES(3), .IDLE_BIT(1'b1), .MSB_FIRST(1'b1)) dut1 (
        .clock (clock),
        .reset (rst1),
        .bus   (if1)
    );

    int         errors = 0;
    int         checks = 0;
    int         hs0 = 0;
    int         hs1 = 0;
    bit         mon_en = 1'b0;
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected bits of one word as {bit, last}, MSB first, parity appended.
    task automatic push_word(input int id, input logic [W-1:0] d);
        logic [1:0] e;
        for (int i = 0; i < W; i++) begin
            e = {d[W-1-i], (i == W - 1) && (PAR == 0)};
            if (id == 0) q0.push_back(e); else q1.push_back(e);
        end
        for (int i = 0; i < PAR; i++) begin
            e = {^d, 1'b1};
            if (id == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    always @(posedge clock) begin
        if (!rst0 && if0.in_valid && if0.in_ready) begin
            hs0 <= hs0 + 1;
            push_word(0, if0.in_data);
        end
        if (!rst1 && if1.in_valid && if1.in_ready) begin
            hs1 <= hs1 + 1;
            push_word(1, if1.in_data);
        end
    end

    always @(negedge clock) begin
        logic [1:0] e;
        if (mon_en) begin
            if (if0.bit_valid === 1'b1) begin
                chk("d0_queue_has_entry", 32'(q0.size() != 0), 1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("d0_bit", if0.bit_out, e[1]);
                    chk("d0_last", if0.last, e[0]);
                end
            end else begin
                chk("d0_idle_level", if0.bit_out, 0);
                chk("d0_idle_last", if0.last, 0);
            end
            if (if1.bit_valid === 1'b1) begin
                chk("d1_queue_has_entry", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("d1_bit", if1.bit_out, e[1]);
                    chk("d1_last", if1.last, e[0]);
                end
            end else begin
                chk("d1_idle_level", if1.bit_out, 1);
                chk("d1_idle_last", if1.last, 0);
            end
        end
    end

    // Sends one word to dut0 from a negedge and checks every cycle of it.
    task automatic send0(input logic [W-1:0] d);
        logic exp_bit;
        if0.in_data  = d;
        if0.in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if0.in_valid = 1'b0;
        if0.in_data  = ~d;
        for (int i = 1; i <= WL; i++) begin
            if (i > 1) @(negedge clock);
            exp_bit = (i <= W) ? d[W-i] : ^d;
            chk("word_bit_valid", if0.bit_valid, 1);
            chk("word_bit_out", if0.bit_out, exp_bit);
            chk("word_last", if0.last, (i == WL));
            chk("word_in_ready", if0.in_ready, (i == WL));
            chk("word_busy", if0.busy, 1);
        end
        @(negedge clock);
        chk("after_word_valid", if0.bit_valid, 0);
        chk("after_word_busy", if0.busy, 0);
        chk("after_word_ready", if0.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          base;
        logic [15:0] stream;
        rst0 = 1'b1;
        rst1 = 1'b1;
        if0.in_valid = 1'b0;
        if0.in_data  = '0;
        if1.in_valid = 1'b0;
        if1.in_data  = '0;
        repeat (3) @(negedge clock);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clock);

        chk("rst0_bit_out", if0.bit_out, 0);
        chk("rst0_bit_valid", if0.bit_valid, 0);
        chk("rst0_last", if0.last, 0);
        chk("rst0_busy", if0.busy, 0);
        chk("rst0_in_ready", if0.in_ready, 1);
        chk("rst1_bit_out", if1.bit_out, 1);
        chk("rst1_bit_valid", if1.bit_valid, 0);
        chk("rst1_busy", if1.busy, 0);
        chk("rst1_in_ready", if1.in_ready, 1);
        mon_en = 1'b1;

        // Single words, including the parity cases.
        send0(8'hB4);
        send0(8'h07);

        // Back-to-back words with in_valid held high.
        base = hs0;
        stream = '0;
        if0.in_data  = 8'hF0;
        if0.in_valid = 1'b1;
        @(posedge clock);
        for (int i = 1; i <= 2 * WL; i++) begin
            @(negedge clock);
            chk("b2b_no_bubble", if0.bit_valid, 1);
            if ((i <= W) || ((i > WL) && (i <= WL + W))) stream = {stream[14:0], if0.bit_out};
            if (i == 1) if0.in_data = 8'h0F;
            if (i == WL + 1) if0.in_valid = 1'b0;
        end
        @(negedge clock);
        chk("b2b_end_valid", if0.bit_valid, 0);
        chk("b2b_handshakes", hs0 - base, 2);
        chk("b2b_stream", stream, 16'hF00F);

        // in_valid held for 16 edges; in_data scrambled outside handshake edges.
        base = hs0;
        for (int i = 0; i < 16; i++) begin
            if0.in_data  = ((i % WL) == 0) ? 8'hAA : 8'($urandom_range(0, 255));
            if0.in_valid = 1'b1;
            @(negedge clock);
        end
        if0.in_valid = 1'b0;
        repeat (WL + 2) @(negedge clock);
        chk("hold_handshakes", hs0 - base, 2);
        chk("hold_idle_busy", if0.busy, 0);

        // Reset in the middle of a word, then reset racing a handshake.
        if0.in_data  = 8'hAA;
        if0.in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if0.in_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("midword_valid", if0.bit_valid, 1);
        rst0 = 1'b1;
        if0.in_data  = 8'h3C;
        if0.in_valid = 1'b1;
        @(negedge clock);
        chk("rstmid_bit_out", if0.bit_out, 0);
        chk("rstmid_valid", if0.bit_valid, 0);
        chk("rstmid_last", if0.last, 0);
        chk("rstmid_busy", if0.busy, 0);
        chk("rstmid_ready", if0.in_ready, 1);
        @(negedge clock);
        rst0 = 1'b0;
        if0.in_valid = 1'b0;
        q0.delete();
        chk("rst_wins_busy", if0.busy, 0);
        chk("rst_wins_valid", if0.bit_valid, 0);
        @(negedge clock);
        chk("rst_wins_still_idle", if0.busy, 0);
        send0(8'h55);

        // Inter-word gap on dut1 with in_valid kept high.
        base = hs1;
        if1.in_data  = 8'hFF;
        if1.in_valid = 1'b1;
        @(posedge clock);
        for (int i = 1; i <= WL + 3; i++) begin
            @(negedge clock);
            if (i == 1) if1.in_data = 8'h81;
            chk("gap_in_ready", if1.in_ready, 0);
            chk("gap_busy", if1.busy, 1);
            chk("gap_bit_valid", if1.bit_valid, (i <= WL));
            chk("gap_bit_out", if1.bit_out, (i <= W) ? 1'b1 : ((i <= WL) ? 1'b0 : 1'b1));
        end
        chk("gap_one_handshake", hs1 - base, 1);
        @(negedge clock);
        chk("gap_end_ready", if1.in_ready, 1);
        chk("gap_end_busy", if1.busy, 0);
        chk("gap_end_valid", if1.bit_valid, 0);
        @(negedge clock);
        if1.in_valid = 1'b0;
        chk("gap_second_handshake", hs1 - base, 2);
        chk("gap_second_word_valid", if1.bit_valid, 1);

        for (int n = 0; n < 60 && (q0.size() != 0 || q1.size() != 0); n++) @(negedge clock);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
